boid_mem_scheduler: RTL and testbench

Arbitrates the single-port 1-bit boid frame memory between the VGA pixel read path and a per-frame update sequencer. On each frame boundary it erases the previous boid pixels, fetches the new positions from the boid position table, and writes the new pixels. VGA reads always win the port whenever the display is active. It sits between the VGA controller, the boid position table and the frame memory.

---
 rtl/boid_mem_scheduler_if.sv | 33 +++
 rtl/boid_mem_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_boid_mem_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boid_mem_scheduler_if.sv
// Bus bundle between the boid memory scheduler and its neighbours:
// VGA controller, boid position table and the 1-bit frame memory.
interface boid_mem_scheduler_if #(
    parameter int IDX_WIDTH  = 4,
    parameter int ADDR_WIDTH = 20
);
    logic                  frame_start;
    logic                  vga_active;
    logic [ADDR_WIDTH-1:0] vga_addr;
    logic                  vga_data;
    logic [IDX_WIDTH-1:0]  boid_idx;
    logic [9:0]            boid_x;
    logic [8:0]            boid_y;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic                  mem_wdata;
    logic                  mem_rdata;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    // scheduler side
    modport master (
        input  frame_start, vga_active, vga_addr, boid_x, boid_y, mem_rdata,
        output vga_data, boid_idx, mem_addr, mem_we, mem_wdata, busy, done, overrun
    );

    // environment side (VGA, position table, memory)
    modport slave (
        output frame_start, vga_active, vga_addr, boid_x, boid_y, mem_rdata,
        input  vga_data, boid_idx, mem_addr, mem_we, mem_wdata, busy, done, overrun
    );
endinterface

// File: rtl/boid_mem_scheduler.sv
// Boid frame memory scheduler: shares the single-port 1-bit frame memory
// between VGA reads (always first) and a per-frame erase/fetch/draw pass.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a frame_start rising edge; VGA owns the port
// S_ERASE | clear the pixel drawn last frame for boid idx (if valid)
// S_FETCH | present boid_idx to the position table (1-cycle latency)
// S_DRAW  | write the new pixel for boid idx and record it in the shadow
// S_DONE  | one-cycle done pulse
module boid_mem_scheduler #(
    parameter int NUM_BOIDS  = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    boid_mem_scheduler_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_FETCH,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BOIDS - 1);

    state_t                state;
    state_t                state_nxt;
    logic [IDX_WIDTH-1:0]  idx;
    logic [IDX_WIDTH-1:0]  idx_nxt;
    logic                  fs_q;
    logic                  start_q;
    logic                  overrun_q;
    logic [NUM_BOIDS-1:0]  valid;
    logic [18:0]           old_addr [NUM_BOIDS];

    logic [18:0]           draw_addr;
    logic                  in_range;
    logic                  last;
    logic                  grant;
    logic                  we;
    logic                  wdata;
    logic                  shadow_set;
    logic                  shadow_clr;
    logic [ADDR_WIDTH-1:0] seq_addr;

    // pixel address = x + 640*y, with 640*y built from shifts (512y + 128y)
    always_comb begin
        draw_addr = {9'd0, bus.boid_x}
                  + ({10'd0, bus.boid_y} << 9)
                  + ({10'd0, bus.boid_y} << 7);
        in_range  = (bus.boid_x < 10'd640) && (bus.boid_y < 9'd480);
        last      = (idx == LAST_IDX);
    end

    // frame_start edge is registered so the pass begins one cycle after it is seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fs_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            fs_q    <= bus.frame_start;
            start_q <= bus.frame_start & ~fs_q;
        end
    end

    // state and boid index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // next state, port grant and write controls; stalled cycles change nothing
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        grant      = 1'b0;
        we         = 1'b0;
        wdata      = 1'b0;
        shadow_set = 1'b0;
        shadow_clr = 1'b0;
        seq_addr   = bus.vga_addr;
        case (state)
            S_IDLE: begin
                if (start_q) begin
                    idx_nxt   = '0;
                    state_nxt = S_ERASE;
                end
            end
            S_ERASE: begin
                if (!bus.vga_active) begin
                    grant    = 1'b1;
                    seq_addr = ADDR_WIDTH'(old_addr[idx]);
                    we       = valid[idx];
                    if (last) begin
                        idx_nxt   = '0;
                        state_nxt = S_FETCH;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            S_FETCH: begin
                state_nxt = S_DRAW;
            end
            S_DRAW: begin
                if (!bus.vga_active) begin
                    grant    = 1'b1;
                    seq_addr = ADDR_WIDTH'(draw_addr);
                    if (in_range) begin
                        we         = 1'b1;
                        wdata      = 1'b1;
                        shadow_set = 1'b1;
                    end else begin
                        shadow_clr = 1'b1;
                    end
                    if (last) begin
                        idx_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // shadow valid bits track which boids left a pixel in memory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (shadow_set) begin
            valid[idx] <= 1'b1;
        end else if (shadow_clr) begin
            valid[idx] <= 1'b0;
        end
    end

    // shadow addresses need no reset; they are only read behind a valid bit
    always_ff @(posedge clk) begin
        if (shadow_set) begin
            old_addr[idx] <= draw_addr;
        end
    end

    // sticky overrun: a new frame arrived before the previous pass finished
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (start_q && (state != S_IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.mem_addr  = grant ? seq_addr : bus.vga_addr;
    assign bus.mem_we    = we;
    assign bus.mem_wdata = wdata;
    assign bus.vga_data  = bus.mem_rdata;
    assign bus.boid_idx  = idx;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_boid_mem_scheduler.sv
// Directed bench for boid_mem_scheduler: a registered position table model,
// a write log per frame, and hand-computed expected write lists.
module tb_boid_mem_scheduler;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    boid_mem_scheduler_if #(.IDX_WIDTH(4), .ADDR_WIDTH(20)) bus ();

    boid_mem_scheduler #(
        .NUM_BOIDS (16),
        .IDX_WIDTH (4),
        .ADDR_WIDTH(20)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // position table: data appears one cycle after boid_idx
    logic [9:0] bx [16];
    logic [8:0] by [16];
    always @(posedge clk) begin
        bus.boid_x <= bx[bus.boid_idx];
        bus.boid_y <= by[bus.boid_idx];
    end

    // observed writes of one frame
    int          wn;
    logic [19:0] w_addr [32];
    logic        w_data [32];
    logic [3:0]  w_idx  [32];
    int          w_len  [32];

    // expected writes of one frame
    int          en;
    logic [19:0] e_addr [8];
    logic        e_data [8];
    logic [3:0]  e_idx  [8];

    int f_len, f_dones, f_done_pos, f_stall_we, f_stall_bad, f_timeout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_clear();
        en = 0;
    endtask

    task automatic expect_w(input logic [3:0] i, input logic [19:0] a, input logic d);
        e_idx[en]  = i;
        e_addr[en] = a;
        e_data[en] = d;
        en++;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, wn, en);
        for (int k = 0; k < en; k++) begin
            if (k < wn) begin
                chk($sformatf("%s_w%0d_idx", tag, k),  w_idx[k],  e_idx[k]);
                chk($sformatf("%s_w%0d_addr", tag, k), w_addr[k], e_addr[k]);
                chk($sformatf("%s_w%0d_data", tag, k), w_data[k], e_data[k]);
            end
        end
    endtask

    // one update pass; optional VGA stall window, overrun edge and reset point
    task automatic run_frame(input int stall_at, input int stall_len,
                             input int ovr_at, input int rst_at);
        logic [3:0] held;
        held = 4'd0;
        wn = 0; f_len = 0; f_dones = 0; f_done_pos = 0;
        f_stall_we = 0; f_stall_bad = 0; f_timeout = 1;
        @(posedge clk); #1 bus.frame_start = 1'b1;
        @(posedge clk); #1;
        chk("start_latency_idle", bus.busy, 1'b0);
        bus.frame_start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (c == 0) chk("start_latency_erase", bus.busy, 1'b1);
            if (!bus.busy) begin
                f_timeout = 0;
                break;
            end
            f_len++;
            bus.vga_active = (stall_len > 0) && (f_len >= stall_at) && (f_len < stall_at + stall_len);
            if (f_len == ovr_at)     bus.frame_start = 1'b1;
            if (f_len == ovr_at + 2) bus.frame_start = 1'b0;
            if (f_len == rst_at)     rst_n = 1'b0;
            #1;
            if (f_len == rst_at) begin
                chk("rst_busy",     bus.busy,     1'b0);
                chk("rst_overrun",  bus.overrun,  1'b0);
                chk("rst_done",     bus.done,     1'b0);
                chk("rst_we",       bus.mem_we,   1'b0);
                chk("rst_boid_idx", bus.boid_idx, 4'd0);
                chk("rst_mem_addr", bus.mem_addr, 20'd1234);
                f_timeout = 0;
                break;
            end
            if (bus.mem_we) begin
                if (wn < 32) begin
                    w_addr[wn] = bus.mem_addr;
                    w_data[wn] = bus.mem_wdata;
                    w_idx[wn]  = bus.boid_idx;
                    w_len[wn]  = f_len;
                end
                wn++;
            end
            if (bus.vga_active) begin
                if (bus.mem_we) f_stall_we++;
                if (f_len == stall_at) held = bus.boid_idx;
                else if (bus.boid_idx != held) f_stall_bad++;
                if (bus.mem_addr != bus.vga_addr) f_stall_bad++;
            end
            if (bus.done) begin
                f_dones++;
                f_done_pos = f_len;
            end
        end
        bus.vga_active  = 1'b0;
        bus.frame_start = 1'b0;
        chk("frame_timeout", f_timeout, 0);
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.vga_active  = 1'b0;
        bus.vga_addr    = 20'd1234;
        bus.mem_rdata   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bx[i] = 10'd800;
            by[i] = 9'd0;
        end
        bx[3]  = 10'd10;  by[3]  = 9'd2;
        bx[5]  = 10'd100; by[5]  = 9'd1;
        bx[15] = 10'd0;   by[15] = 9'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_addr", bus.mem_addr,  20'd1234);
        chk("reset_we",       bus.mem_we,    1'b0);
        chk("reset_wdata",    bus.mem_wdata, 1'b0);
        chk("reset_busy",     bus.busy,      1'b0);
        chk("reset_done",     bus.done,      1'b0);
        chk("reset_overrun",  bus.overrun,   1'b0);
        chk("reset_boid_idx", bus.boid_idx,  4'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_mem_addr", bus.mem_addr, 20'd1234);
        chk("idle_busy",     bus.busy,     1'b0);
        bus.mem_rdata = 1'b1; #1;
        chk("vga_data_1", bus.vga_data, 1'b1);
        bus.mem_rdata = 1'b0; #1;
        chk("vga_data_0", bus.vga_data, 1'b0);

        // frame 1: empty shadow, three on-screen boids
        run_frame(0, 0, 0, 0);
        expect_clear();
        expect_w(4'd3,  20'd1290, 1'b1);
        expect_w(4'd5,  20'd740,  1'b1);
        expect_w(4'd15, 20'd0,    1'b1);
        check_writes("f1");
        chk("f1_len",      f_len,      49);
        chk("f1_dones",    f_dones,    1);
        chk("f1_done_pos", f_done_pos, 49);

        // frame 2: boid 3 to the far corner, others off-screen at the boundaries
        bx[3]  = 10'd639; by[3]  = 9'd479;
        bx[5]  = 10'd700; by[5]  = 9'd10;
        bx[15] = 10'd640; by[15] = 9'd0;
        bx[7]  = 10'd0;   by[7]  = 9'd480;
        run_frame(0, 0, 0, 0);
        expect_clear();
        expect_w(4'd3,  20'd1290,   1'b0);
        expect_w(4'd5,  20'd740,    1'b0);
        expect_w(4'd15, 20'd0,      1'b0);
        expect_w(4'd3,  20'd307199, 1'b1);
        check_writes("f2");
        chk("f2_len", f_len, 49);

        // frame 3: coincident boids 0 and 3, 7-cycle VGA stall at DRAW of boid 3
        bx[0] = 10'd639; by[0] = 9'd479;
        run_frame(24, 7, 0, 0);
        expect_clear();
        expect_w(4'd3, 20'd307199, 1'b0);
        expect_w(4'd0, 20'd307199, 1'b1);
        expect_w(4'd3, 20'd307199, 1'b1);
        check_writes("f3");
        chk("f3_len",       f_len,       56);
        chk("f3_dones",     f_dones,     1);
        chk("f3_done_pos",  f_done_pos,  56);
        chk("f3_stall_we",  f_stall_we,  0);
        chk("f3_stall_bad", f_stall_bad, 0);
        if (wn > 2) chk("f3_post_stall_write_len", w_len[2], 31);
        chk("f3_overrun", bus.overrun, 1'b0);

        // frame 4: frame_start rises during ERASE
        run_frame(0, 0, 5, 0);
        expect_clear();
        expect_w(4'd0, 20'd307199, 1'b0);
        expect_w(4'd3, 20'd307199, 1'b0);
        expect_w(4'd0, 20'd307199, 1'b1);
        expect_w(4'd3, 20'd307199, 1'b1);
        check_writes("f4");
        chk("f4_len",     f_len,       49);
        chk("f4_dones",   f_dones,     1);
        chk("f4_overrun", bus.overrun, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("f4_no_restart", bus.busy,    1'b0);
        chk("f4_overrun_sticky", bus.overrun, 1'b1);

        // frame 5: reset during DRAW of boid 1
        run_frame(0, 0, 0, 20);
        expect_clear();
        expect_w(4'd0, 20'd307199, 1'b0);
        expect_w(4'd3, 20'd307199, 1'b0);
        expect_w(4'd0, 20'd307199, 1'b1);
        check_writes("f5");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // frame 6: shadow cleared by reset, so ERASE writes nothing
        run_frame(0, 0, 0, 0);
        expect_clear();
        expect_w(4'd0, 20'd307199, 1'b1);
        expect_w(4'd3, 20'd307199, 1'b1);
        check_writes("f6");
        chk("f6_len", f_len, 49);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
